alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
- Registered issue stage directly upstream of the 32-bit ALU datapath (AND, OR, add/sub, shift units).
- Captures operands, opcode and shift amount from the decode/regfile stage over a valid/ready handshake.
- Holds them in a 2-entry skid buffer and presents them to the ALU with a pre-decoded one-hot unit select.
- Breaks the timing path between regfile read and the ALU bit-slice logic without dropping or duplicating operations under backpressure.

Parameters:
- WIDTH, 32, operand width in bits.
- OPW, 5, opcode width in bits.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  upstream offers an operation.
- in_ready  output  1  stage can accept; registered.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_opcode  input  OPW  ALU opcode.
- in_shamt  input  5  shift amount.
- out_valid  output  1  operation presented to ALU.
- out_ready  input  1  ALU/downstream consumes.
- out_a  output  WIDTH  registered operand A.
- out_b  output  WIDTH  registered operand B.
- out_opcode  output  OPW  registered opcode.
- out_shamt  output  5  registered shift amount.
- out_sel  output  6  one-hot unit select: bit0 ADD, bit1 SUB, bit2 AND, bit3 OR, bit4 SLL, bit5 SRA.
- out_illegal  output  1  opcode not in {00000..00101}; out_sel is 0 when set.

Behaviour:
- Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
- Storage: main register (drives out_*) and skid register. State machine:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: main and skid valid.
- Transitions:
  - EMPTY + in -> ONE; input loads main.
  - ONE + in + out -> ONE; input loads main.
  - ONE + in, no out -> FULL; input loads skid.
  - ONE + out, no in -> EMPTY.
  - FULL + out -> ONE; skid moves to main.
  - FULL with no out holds.
- in_ready = 0 only in FULL. in_ready is a flop, not combinational from out_ready. In FULL, in_valid is ignored.
- Latency: an accepted op appears on out_* on the next clock edge when the stage was EMPTY, or was ONE with out taken the same cycle.
- Order strictly FIFO. No drop, no duplicate.
- out_* stable while out_valid=1 and out_ready=0.
- out_sel and out_illegal are decoded from opcode at load time and stored with the entry; they are not decoded combinationally at the output.
- Opcode 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLL, 00101 SRA. Any other opcode: out_sel=0, out_illegal=1. An illegal op still flows and handshakes normally.
- Reset (async assert, may occur mid-transfer):
  - State EMPTY.
  - out_valid=0, in_ready=1 one cycle after reset deassertion (0 while reset asserted).
  - out_a/out_b/out_opcode/out_shamt/out_sel = 0, out_illegal = 0. Skid contents cleared.
  - In-flight entries are discarded.
- Deassertion is synchronised externally; the block samples it on the next rising edge.
- in_valid/out_ready of X during reset are don't-care.

Optional Feature:
- Macro ALU_OPERAND_STAGE_PERF_EN.
- Defined: adds outputs perf_issued[31:0] (counts transfer-out cycles) and perf_stall[31:0] (counts cycles with out_valid=1 and out_ready=0).
  - Both cleared by reset.
  - Both wrap from 0xFFFFFFFF to 0 silently.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then single op a=0xFFFF0000, b=0x0F0F0F0F, opcode=00010, out_ready=1 -> next cycle out_valid=1, out_a/out_b match, out_sel=000100, out_illegal=0; following cycle out_valid=0.
- Back-to-back stream of 8 ops with out_ready=1 every cycle -> in_ready stays 1, one op out per cycle in order, throughput 1/cycle.
- Hold out_ready=0 while offering 3 ops -> first two accepted, in_ready=0 after second; third held upstream. Raise out_ready -> ops emerge 1,2,3 in order, no loss.
- Opcode 00111 with a=5, b=3 -> out_illegal=1, out_sel=000000, handshake completes normally.
- Assert reset low mid-stream in FULL state -> out_valid=0, in_ready=0 during reset, outputs zero; after release in_ready=1 next edge, no stale op emitted.
- With ALU_OPERAND_STAGE_PERF_EN: 10 transfers with 4 stall cycles interleaved -> perf_issued=10, perf_stall=4. Preload-to-wrap check: 0xFFFFFFFF + 1 transfer -> perf_issued=0.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Registered issue stage in front of the ALU: 2-entry skid buffer with a pre-decoded unit select.
// Optional perf counters are enabled with ALU_OPERAND_STAGE_PERF_EN.
module alu_operand_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_opcode,
  input  logic [4:0]       in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [OPW-1:0]   out_opcode,
  output logic [4:0]       out_shamt,
  output logic [5:0]       out_sel,
  output logic             out_illegal
`ifdef ALU_OPERAND_STAGE_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   opcode;
    logic [4:0]       shamt;
    logic [5:0]       sel;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   in_ready_q;
  logic   in_xfer;
  logic   out_xfer;

  // Decode once on the way in so the ALU sees a flopped one-hot select.
  always_comb begin
    in_entry         = '0;
    in_entry.a       = in_a;
    in_entry.b       = in_b;
    in_entry.opcode  = in_opcode;
    in_entry.shamt   = in_shamt;
    in_entry.sel     = '0;
    in_entry.illegal = 1'b0;
    if (in_opcode <= OPW'(5)) begin
      in_entry.sel = 6'(6'b000001 << in_opcode[2:0]);
    end else begin
      in_entry.illegal = 1'b1;
    end
  end

  assign in_xfer   = in_valid & in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          main_d  = in_entry;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          main_d = in_entry;
        end else if (in_xfer) begin
          skid_d  = in_entry;
          state_d = StFull;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // in_ready is held low during reset and rises on the first edge after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != StFull);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_opcode  = main_q.opcode;
  assign out_shamt   = main_q.shamt;
  assign out_sel     = main_q.sel;
  assign out_illegal = main_q.illegal;

`ifdef ALU_OPERAND_STAGE_PERF_EN
  logic [31:0] perf_issued_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (out_xfer) begin
        perf_issued_q <= perf_issued_q + 32'd1;
      end
      if (out_valid && !out_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
